amba_test: RTL and testbench

CPU-side memory port bridged onto an internal APB-style bus with two slaves: a word RAM and a memory-mapped I/O slave (switch input, LED output). It sits between the CPU datapath (MemRead/MemWrite/Adress/WriteData) and memory/board I/O, and stalls the CPU through `isLocked` while a bus transfer is in flight. All accesses are 32-bit words; there are no byte enables.

---
 rtl/amba_test_pkg.sv | 42 ++++
 rtl/amba_test_if.sv | 33 +++
 rtl/amba_test_apb_ram_slave.sv | 49 ++++
 rtl/amba_test.sv | 155 +++++++++++++++
 tb/tb_amba_test.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/amba_test_pkg.sv
// -----------------------------------------------------------------------------
// amba_test_pkg
// Shared definitions for the CPU-to-APB memory bridge:
//   - bridge FSM state encoding
//   - default address map (RAM words, switch and LED register addresses)
//   - internal APB bus records (request from the bridge, response from a slave)
// -----------------------------------------------------------------------------
package amba_test_pkg;

    // Default address map, in word addresses.
    localparam int DEFAULT_RAM_WORDS = 15;
    localparam int DEFAULT_SW_ADDR   = 15;
    localparam int DEFAULT_LED_ADDR  = 16;

    // Slave select positions inside the PSEL vector.
    localparam int NUM_SLAVES = 2;
    localparam int SEL_RAM    = 0;
    localparam int SEL_IO     = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bridge-driven half of the APB bus.
    typedef struct packed {
        logic [31:0]           paddr;
        logic [31:0]           pwdata;
        logic                  pwrite;
        logic [NUM_SLAVES-1:0] psel;
        logic                  penable;
    } apb_req_t;

    // Slave-driven half of the APB bus (after the read-data mux).
    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
    } apb_rsp_t;

endpackage

// File: rtl/amba_test_if.sv
// -----------------------------------------------------------------------------
// amba_test_if
// CPU memory port plus board I/O of the bridge, bundled into one interface.
//   Adress, WriteData  : word address / write data of the CPU access
//   MemRead, MemWrite  : request lines, held by the CPU until completion
//   MemData            : last completed read data
//   isLocked           : CPU stall while a request is pending or in flight
//   SW                 : board switches
//   LED                : board LEDs
// Modports:
//   master : the CPU/board side (drives requests and switches)
//   slave  : the bridge (drives read data, stall and LEDs)
// -----------------------------------------------------------------------------
interface amba_test_if;
    logic [31:0] Adress;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemData;
    logic        isLocked;
    logic [31:0] SW;
    logic [31:0] LED;

    modport master (
        output Adress, WriteData, MemRead, MemWrite, SW,
        input  MemData, isLocked, LED
    );

    modport slave (
        input  Adress, WriteData, MemRead, MemWrite, SW,
        output MemData, isLocked, LED
    );
endinterface

// File: rtl/amba_test_apb_ram_slave.sv
// -----------------------------------------------------------------------------
// apb_ram_slave
// Zero-wait-state APB word RAM. Writes commit on the rising edge that ends the
// ACCESS phase; reads are combinational while the slave is selected.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset; only blocks a pending write
//   i_psel     slave select
//   i_penable  ACCESS phase
//   i_pwrite   1 = write, 0 = read
//   i_paddr    word index into the array
//   i_pwdata   write data
//   o_prdata   read data (0 when not selected)
//   o_pready   always ready
// -----------------------------------------------------------------------------
module apb_ram_slave #(
    parameter int WORDS  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [31:0]       i_pwdata,
    output logic [31:0]       o_prdata,
    output logic              o_pready
);

    logic [31:0] r_mem [WORDS];
    logic        w_we;

    // A reset landing on the ACCESS edge aborts the transfer, so it also
    // suppresses the write.
    assign w_we = i_psel && i_penable && i_pwrite && !reset;

    // NOTE: the array has no reset branch; clearing storage on reset would
    // prevent mapping onto RAM macros, and contents are meant to survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[i_paddr] <= i_pwdata;
        end
    end

    assign o_prdata = i_psel ? r_mem[i_paddr] : 32'd0;
    assign o_pready = 1'b1;

endmodule

// File: rtl/amba_test.sv
// -----------------------------------------------------------------------------
// amba_test
// Bridges the CPU memory port onto an internal APB bus with two slaves:
// a word RAM (apb_ram_slave) and an I/O slave (switch read, LED register).
// Each accepted request runs IDLE -> SETUP -> ACCESS -> DONE; the CPU is
// stalled through isLocked until the ACCESS phase has finished.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    CPU/board interface (slave modport): Adress, WriteData, MemRead,
//          MemWrite, SW in; MemData, isLocked, LED out
// -----------------------------------------------------------------------------
module amba_test
    import amba_test_pkg::*;
#(
    parameter int RAM_WORDS = DEFAULT_RAM_WORDS,
    parameter int SW_ADDR   = DEFAULT_SW_ADDR,
    parameter int LED_ADDR  = DEFAULT_LED_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    amba_test_if.slave  bus
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_mem_data;
    logic [31:0] r_led;

    logic                  w_req_any;
    logic [NUM_SLAVES-1:0] w_decode;
    apb_req_t              w_req;
    apb_rsp_t              w_rsp;
    logic [31:0]           w_ram_prdata;
    logic                  w_ram_pready;
    logic [31:0]           w_io_prdata;
    logic                  w_io_pready;
    logic                  w_access_done;

    assign w_req_any = bus.MemRead || bus.MemWrite;

    // Address decode: RAM owns the low words; every other address goes to the
    // I/O slave, which also absorbs unmapped accesses (read 0, write ignored).
    always_comb begin
        w_decode = '0;
        if (r_addr < 32'(RAM_WORDS)) begin
            w_decode[SEL_RAM] = 1'b1;
        end else begin
            w_decode[SEL_IO] = 1'b1;
        end
    end

    // APB request driven from the latched CPU access.
    always_comb begin
        w_req.paddr   = r_addr;
        w_req.pwdata  = r_wdata;
        w_req.pwrite  = r_write;
        w_req.psel    = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) ? w_decode : '0;
        w_req.penable = (r_state == ST_ACCESS);
    end

    apb_ram_slave #(
        .WORDS  (RAM_WORDS),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_psel    (w_req.psel[SEL_RAM]),
        .i_penable (w_req.penable),
        .i_pwrite  (w_req.pwrite),
        .i_paddr   (w_req.paddr[RAM_AW-1:0]),
        .i_pwdata  (w_req.pwdata),
        .o_prdata  (w_ram_prdata),
        .o_pready  (w_ram_pready)
    );

    // I/O slave read side: switches, LED readback, zero for unmapped words.
    always_comb begin
        w_io_prdata = 32'd0;
        if (w_req.psel[SEL_IO]) begin
            if (w_req.paddr == 32'(SW_ADDR)) begin
                w_io_prdata = bus.SW;
            end else if (w_req.paddr == 32'(LED_ADDR)) begin
                w_io_prdata = r_led;
            end
        end
    end
    assign w_io_pready = 1'b1;

    // Response mux: exactly one slave is selected during SETUP/ACCESS.
    always_comb begin
        w_rsp.prdata = w_io_prdata;
        w_rsp.pready = w_io_pready;
        if (w_req.psel[SEL_RAM]) begin
            w_rsp.prdata = w_ram_prdata;
            w_rsp.pready = w_ram_pready;
        end
    end

    assign w_access_done = (r_state == ST_ACCESS) && w_rsp.pready;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_any) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (w_rsp.pready) w_next = ST_DONE;
            // A request still held after completion must not start another.
            ST_DONE:   if (!w_req_any) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_write    <= 1'b0;
            r_mem_data <= 32'd0;
            r_led      <= 32'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_req_any) begin
                r_addr  <= bus.Adress;
                r_wdata <= bus.WriteData;
                // Write wins when both request lines are high.
                r_write <= bus.MemWrite;
            end
            if (w_access_done) begin
                if (!r_write) begin
                    r_mem_data <= w_rsp.prdata;
                end else if (w_req.psel[SEL_IO] && (r_addr == 32'(LED_ADDR))) begin
                    r_led <= r_wdata;
                end
            end
        end
    end

    // Stall starts combinationally in the request cycle.
    assign bus.isLocked = ((r_state == ST_IDLE) && w_req_any) ||
                          (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign bus.MemData  = r_mem_data;
    assign bus.LED      = r_led;

endmodule

// File: tb/tb_amba_test.sv
// -----------------------------------------------------------------------------
// tb_amba_test
// Self-checking bench for amba_test. Stimulus tasks update a word-level model
// of the address map and push the expected MemData/LED values; a monitor pops
// and compares whenever isLocked falls (a transfer has completed).
// -----------------------------------------------------------------------------
module tb_amba_test;
    import amba_test_pkg::*;

    localparam int M_RAM_WORDS = 15;
    localparam int M_SW_ADDR   = 15;
    localparam int M_LED_ADDR  = 16;

    typedef struct {
        logic [31:0] mem_data;
        logic [31:0] led;
    } exp_t;

    logic clk;
    logic reset;

    amba_test_if bus ();

    amba_test #(
        .RAM_WORDS (M_RAM_WORDS),
        .SW_ADDR   (M_SW_ADDR),
        .LED_ADDR  (M_LED_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    exp_t exp_q[$];

    // Reference model state.
    logic [31:0] m_ram [M_RAM_WORDS];
    logic [31:0] m_led;
    logic [31:0] m_mem;
    logic [31:0] m_sw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a falling isLocked marks a completed transfer.
    logic prev_lock = 1'b0;
    always @(negedge clk) begin
        if (!reset && prev_lock && !bus.isLocked) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("MemData", bus.MemData, e.mem_data);
                check("LED", bus.LED, e.led);
            end
        end
        prev_lock = bus.isLocked;
    end

    // One CPU access. early_drop releases the request after the first edge;
    // extra_hold keeps it asserted that many cycles past completion.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic rd, input logic wr,
                             input bit early_drop, input int extra_hold);
        exp_t e;
        int   cyc;
        if (wr) begin
            if (addr < 32'(M_RAM_WORDS)) m_ram[addr[3:0]] = wdata;
            else if (addr == 32'(M_LED_ADDR)) m_led = wdata;
        end else begin
            if (addr < 32'(M_RAM_WORDS)) m_mem = m_ram[addr[3:0]];
            else if (addr == 32'(M_SW_ADDR)) m_mem = m_sw;
            else if (addr == 32'(M_LED_ADDR)) m_mem = m_led;
            else m_mem = 32'd0;
        end
        e.mem_data = m_mem;
        e.led      = m_led;
        exp_q.push_back(e);

        @(negedge clk);
        #1;
        bus.SW        = m_sw;
        bus.Adress    = addr;
        bus.WriteData = wdata;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        #1;
        check("lock_in_request_cycle", 32'(bus.isLocked), 32'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (early_drop) begin
                #1;
                bus.MemRead  = 1'b0;
                bus.MemWrite = 1'b0;
            end
        end while (bus.isLocked && cyc < 10);
        check("lock_cycles", 32'(cyc), 32'd3);
        for (int i = 0; i < extra_hold; i++) begin
            @(negedge clk);
            check("no_retrigger", 32'(bus.isLocked), 32'd0);
        end
        #1;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Adress    = $urandom;
        bus.WriteData = $urandom;
        @(negedge clk);
    endtask

    // Write that is cut off by reset during its ACCESS phase.
    task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        #1;
        bus.Adress    = addr;
        bus.WriteData = wdata;
        bus.MemWrite  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset        = 1'b1;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        m_led = 32'd0;
        m_mem = 32'd0;
        check("abort_LED", bus.LED, m_led);
        check("abort_MemData", bus.MemData, m_mem);
        check("abort_isLocked", 32'(bus.isLocked), 32'd0);
        check("abort_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] addr;
        logic        rd;
        logic        wr;

        reset         = 1'b1;
        bus.Adress    = 32'd0;
        bus.WriteData = 32'd0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.SW        = 32'd0;
        m_led = 32'd0;
        m_mem = 32'd0;
        m_sw  = 32'd0;

        repeat (2) @(negedge clk);
        check("reset_MemData", bus.MemData, 32'd0);
        check("reset_LED", bus.LED, 32'd0);
        check("reset_isLocked", 32'(bus.isLocked), 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_isLocked", 32'(bus.isLocked), 32'd0);

        // Switch read.
        m_sw = 32'd2;
        do_access(32'd15, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Fill RAM with known words.
        for (int i = 0; i < M_RAM_WORDS; i++) begin
            do_access(32'(i), $urandom, 1'b0, 1'b1, 1'b0, 0);
        end

        // RAM round trip, zero readback, held request not retriggering.
        do_access(32'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 2);
        do_access(32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 2);
        do_access(32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 0);
        do_access(32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // LED write and readback.
        do_access(32'd16, 32'd4, 1'b0, 1'b1, 1'b0, 0);
        do_access(32'd16, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Unmapped write ignored; unmapped read returns 0.
        do_access(32'd100, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        do_access(32'd100, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Both request lines high: behaves as a write.
        do_access(32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 0);
        do_access(32'd16, 32'h0000_00A5, 1'b1, 1'b1, 1'b0, 0);

        // Request dropped during SETUP still completes.
        do_access(32'd5, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 0);
        do_access(32'd5, 32'd0, 1'b1, 1'b0, 1'b1, 0);

        // Reset during ACCESS aborts LED and RAM writes; RAM keeps contents.
        abort_write(32'd16, 32'h0000_00FF);
        abort_write(32'd5, 32'hCAFE_F00D);
        do_access(32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 0);
        do_access(32'd16, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    addr = 32'($urandom_range(0, M_RAM_WORDS - 1));
                2:       addr = 32'(M_SW_ADDR);
                3:       addr = 32'(M_LED_ADDR);
                default: addr = 32'd17 + $urandom_range(0, 100000);
            endcase
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            m_sw = $urandom;
            do_access(addr, $urandom, rd, wr, bit'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
